// File: rtl/muldiv_unit.sv
// Purpose  : iterative MIPS mult/multu/div/divu into HI/LO, plus mthi/mtlo writes.
// Latency  : 32 CALC + 1 FIX cycles; HI/LO written at FIX exit, o_done pulses the next cycle.
// Backpres.: o_busy stalls the hazard unit; a start seen while busy is ignored.
// Ports    : i_clk/i_rst_n (sync, active-low); i_opr1/i_opr2 rs/rt operands;
//            i_op/i_start operation request; i_cancel flush; o_busy, o_done, o_hi, o_lo.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_opr1,
  input  logic [31:0] i_opr2,
  input  logic [2:0]  i_op,
  input  logic        i_start,
  input  logic        i_cancel,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] r_opd;     // |multiplicand| or |divisor|
  logic        r_is_div;
  logic        r_neg_p;   // negate 64-bit product
  logic        r_neg_q;   // negate quotient
  logic        r_neg_r;   // negate remainder (dividend sign)
  logic        r_dz;      // divide by zero: quotient forced to all ones
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_go;
  logic        w_launch;
  logic        w_signed;
  logic        w_div_op;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_diff;
  logic [63:0] w_div_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  // Cancel beats start, and starts are only honoured in IDLE.
  assign w_go     = i_start && !i_cancel && (r_state == S_IDLE);
  assign w_launch = w_go && (i_op == OP_MULT || i_op == OP_MULTU ||
                             i_op == OP_DIV  || i_op == OP_DIVU);
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_div_op = (i_op == OP_DIV) || (i_op == OP_DIVU);

  // Two's-complement negate leaves 0x80000000 unchanged, which is its magnitude as unsigned.
  assign w_a_abs = (w_signed && i_opr1[31]) ? -i_opr1 : i_opr1;
  assign w_b_abs = (w_signed && i_opr2[31]) ? -i_opr2 : i_opr2;

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set,
  // then shift right; the carry lands in bit 63.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

  // Restoring divide: shift the pair left and try subtracting the divisor from the
  // 33-bit shifted remainder; a borrow means restore and record a 0 quotient bit.
  assign w_rem_sh   = r_acc[63:31];
  assign w_rem_diff = w_rem_sh - {1'b0, r_opd};
  assign w_div_nxt  = w_rem_diff[32] ? {r_acc[62:0], 1'b0}
                                     : {w_rem_diff[31:0], r_acc[30:0], 1'b1};

  // Sign fix-up. With a zero divisor the remainder equals the dividend after sign
  // correction, so only the quotient needs overriding.
  assign w_prod   = r_neg_p ? -r_acc : r_acc;
  assign w_quo    = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem    = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
  assign w_fix_hi = r_is_div ? w_rem : w_prod[63:32];
  assign w_fix_lo = r_is_div ? (r_dz ? 32'hFFFF_FFFF : w_quo) : w_prod[31:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_CALC;
      S_CALC: begin
        if (i_cancel)                    w_next = S_IDLE;
        else if (r_cnt == 5'(ITER - 1))  w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_is_div <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_cnt    <= '0;
        r_is_div <= w_div_op;
        r_opd    <= w_div_op ? w_b_abs : w_a_abs;
        r_acc    <= {32'd0, w_div_op ? w_a_abs : w_b_abs};
        r_neg_p  <= w_signed && (i_opr1[31] ^ i_opr2[31]);
        r_neg_q  <= w_signed && (i_opr1[31] ^ i_opr2[31]);
        r_neg_r  <= w_signed && i_opr1[31];
        r_dz     <= (i_opr2 == 32'd0);
      end else if (r_state == S_CALC && !i_cancel) begin
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt + 5'd1;
      end else if (r_state == S_FIX && !i_cancel) begin
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
        r_done <= 1'b1;
      end
      if (w_go && i_op == OP_MTHI) r_hi <= i_opr1;
      if (w_go && i_op == OP_MTLO) r_lo <= i_opr1;
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
